// File: rtl/axi3_modport_slave_if.sv
// AXI3 bus bundle between an interconnect master port and a register-bank slave.
// Carries all five channels; cache/lock/prot/qos/burst/size fields ride along untouched.
interface axi3_modport_slave_if #(
  parameter int ID_WIDTH = 12
) ();
  logic [31:0]         araddr;
  logic [ID_WIDTH-1:0] arid;
  logic [3:0]          arlen;
  logic                arvalid;
  logic [1:0]          arburst;
  logic [2:0]          arsize;
  logic [3:0]          arcache;
  logic [1:0]          arlock;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arready;

  logic [31:0]         rdata;
  logic [ID_WIDTH-1:0] rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [31:0]         awaddr;
  logic [ID_WIDTH-1:0] awid;
  logic [3:0]          awlen;
  logic                awvalid;
  logic [1:0]          awburst;
  logic [2:0]          awsize;
  logic [3:0]          awcache;
  logic [1:0]          awlock;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic [ID_WIDTH-1:0] wid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arid, arlen, arvalid, arburst, arsize, arcache, arlock, arprot, arqos,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awid, awlen, awvalid, awburst, awsize, awcache, awlock, awprot, awqos,
    output awready,
    input  wdata, wstrb, wlast, wvalid, wid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output araddr, arid, arlen, arvalid, arburst, arsize, arcache, arlock, arprot, arqos,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready,
    output awaddr, awid, awlen, awvalid, awburst, awsize, awcache, awlock, awprot, awqos,
    input  awready,
    output wdata, wstrb, wlast, wvalid, wid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi3_modport_slave.sv
// AXI3 slave exposing N_REGS 32-bit registers with single/INCR burst access.
// Independent read and write FSMs; out-of-range beats answer DECERR.
module axi3_modport_slave #(
  parameter int          D_WIDTH   = 32,
  parameter int          ID_WIDTH  = 12,
  parameter int          N_REGS    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                  aclk_i,
  input  logic                  rst_i,
  axi3_modport_slave_if.slave   s_axi,
  output logic [32*N_REGS-1:0]  regs_o
);

  localparam int          IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [30:0] BASE_W = {1'b0, BASE_ADDR[31:2]};
  localparam logic [30:0] NREG_W = 31'(N_REGS);

  typedef enum logic [0:0] {R_IDLE, R_DATA}         rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  // Word addresses carry one extra MSB so a burst near the top of memory never wraps into range.
  function automatic logic in_range(input logic [30:0] w);
    return (w >= BASE_W) && (w < (BASE_W + NREG_W));
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [30:0] w);
    logic [30:0] off;
    off = w - BASE_W;
    return off[IDX_W-1:0];
  endfunction

  logic [31:0] regs_q [N_REGS];

  rstate_e             r_state_q, r_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [30:0]         r_word_q, r_word_d;
  logic [3:0]          r_left_q, r_left_d;
  logic                r_load_s;
  logic [30:0]         r_load_word_s;

  wstate_e             w_state_q, w_state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [30:0]         w_word_q, w_word_d;
  logic [3:0]          w_left_q, w_left_d;
  logic                w_err_q, w_err_d;
  logic                w_beat_oor_s;
  logic                wr_en_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [31:0]         wr_data_s;

  logic unused_s;
  assign unused_s = ^{s_axi.araddr[1:0], s_axi.awaddr[1:0], s_axi.arburst, s_axi.arsize,
                      s_axi.arcache, s_axi.arlock, s_axi.arprot, s_axi.arqos, s_axi.awburst,
                      s_axi.awsize, s_axi.awcache, s_axi.awlock, s_axi.awprot, s_axi.awqos,
                      s_axi.wid};

  always_comb begin
    r_state_d     = r_state_q;
    rid_d         = rid_q;
    r_word_d      = r_word_q;
    r_left_d      = r_left_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    rlast_d       = rlast_q;
    r_load_s      = 1'b0;
    r_load_word_s = r_word_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          r_state_d     = R_DATA;
          rid_d         = s_axi.arid;
          r_left_d      = s_axi.arlen;
          r_load_s      = 1'b1;
          r_load_word_s = {1'b0, s_axi.araddr[31:2]};
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi.rready && rlast_q) begin
          r_state_d = R_IDLE;
        end else if (rvalid_q && s_axi.rready) begin
          r_left_d      = r_left_q - 4'd1;
          r_load_s      = 1'b1;
          r_load_word_s = r_word_q + 31'd1;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Beat data is sampled from the bank before any same-edge write lands.
    if (r_load_s) begin
      r_word_d = r_load_word_s;
      rlast_d  = (r_left_d == 4'd0);
      if (in_range(r_load_word_s)) begin
        rdata_d = regs_q[reg_idx(r_load_word_s)];
        rresp_d = 2'b00;
      end else begin
        rdata_d = 32'h0;
        rresp_d = 2'b11;
      end
    end else begin
      r_word_d = r_word_q;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      r_word_q  <= 31'h0;
      r_left_q  <= 4'd0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      r_word_q  <= r_word_d;
      r_left_q  <= r_left_d;
    end
  end

  assign w_beat_oor_s = !in_range(w_word_q);
  assign wr_idx_s     = reg_idx(w_word_q);

  always_comb begin
    wr_data_s = regs_q[wr_idx_s];
    for (int b = 0; b < 4; b++) begin
      if (s_axi.wstrb[b]) begin
        wr_data_s[8*b +: 8] = s_axi.wdata[8*b +: 8];
      end else begin
        wr_data_s[8*b +: 8] = regs_q[wr_idx_s][8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_word_d  = w_word_q;
    w_left_d  = w_left_q;
    w_err_d   = w_err_q;
    wr_en_s   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && awready_q) begin
          w_state_d = W_DATA;
          bid_d     = s_axi.awid;
          w_word_d  = {1'b0, s_axi.awaddr[31:2]};
          w_left_d  = s_axi.awlen;
          w_err_d   = 1'b0;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_q) begin
          if (w_beat_oor_s) begin
            w_err_d = 1'b1;
            wr_en_s = 1'b0;
          end else begin
            wr_en_s = 1'b1;
          end
          // An early wlast ends the burst even if awlen promised more beats.
          if (s_axi.wlast || (w_left_q == 4'd0)) begin
            w_state_d = W_RESP;
            bresp_d   = (w_err_q || w_beat_oor_s) ? 2'b11 : 2'b00;
          end else begin
            w_left_d = w_left_q - 4'd1;
            w_word_d = w_word_q + 31'd1;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi.bready) begin
          w_state_d = W_IDLE;
          w_err_d   = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      w_word_q  <= 31'h0;
      w_left_q  <= 4'd0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      w_word_q  <= w_word_d;
      w_left_q  <= w_left_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (wr_en_s) begin
      regs_q[wr_idx_s] <= wr_data_s;
    end else begin
      regs_q[wr_idx_s] <= regs_q[wr_idx_s];
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_regs_out
    assign regs_o[32*g +: 32] = regs_q[g];
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;

endmodule

// File: tb/tb_axi3_modport_slave.sv
// Directed bench for axi3_modport_slave: a vector table of single transfers
// plus hand-written burst, back-pressure, back-to-back, early-W and reset sequences.
module tb_axi3_modport_slave;
  logic         aclk = 1'b0;
  logic         rst;
  logic [511:0] regs;

  axi3_modport_slave_if #(.ID_WIDTH(12)) bus ();

  axi3_modport_slave #(
    .D_WIDTH(32), .ID_WIDTH(12), .N_REGS(16), .BASE_ADDR(32'h0)
  ) dut (
    .aclk_i(aclk),
    .rst_i (rst),
    .s_axi (bus),
    .regs_o(regs)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic [15:0] rd_last_v;
  logic [11:0] rd_id;
  int          rd_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [511:0] e;
    for (int i = 0; i < 16; i++) e[32*i +: 32] = model[i];
    tests++;
    if (regs !== e) begin
      fails++;
      $display("FAIL %s: regs got %h expected %h", name, regs, e);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb);
    if (addr < 32'd64) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[5:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                          input logic [31:0] d0, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [11:0] rbid);
    int t;
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 50) begin @(posedge aclk); #1; t++; end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bus.wdata = d0 + 32'(k); bus.wstrb = strb; bus.wlast = (k == int'(len)); bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 50) begin @(posedge aclk); #1; t++; end
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    t = 0;
    while (!bus.bvalid && t < 50) begin @(posedge aclk); #1; t++; end
    check("bvalid seen", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp; rbid = bus.bid;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len);
    int   t;
    logic done;
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arvalid = 1'b1; bus.rready = 1'b1;
    t = 0;
    while (!bus.arready && t < 50) begin @(posedge aclk); #1; t++; end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    rd_n = 0; rd_last_v = 16'h0; done = 1'b0; t = 0;
    while (!done && t < 60) begin
      if (bus.rvalid) begin
        if (rd_n < 16) begin
          rd_data[rd_n] = bus.rdata; rd_resp[rd_n] = bus.rresp; rd_last_v[rd_n] = bus.rlast;
        end
        rd_id = bus.rid;
        rd_n++;
        done = bus.rlast;
      end
      @(posedge aclk); #1; t++;
    end
    bus.rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vec [11];
    logic [1:0]  resp;
    logic [11:0] bid_r;
    logic [31:0] bd [4];
    logic [11:0] bi [4];
    int          nb, acc;
    logic        hs;

    vec[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF,    2'b00, 32'h0};
    vec[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0,    2'b00, 32'hDEAD_BEEF};
    vec[2]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF,    2'b00, 32'h0};
    vec[3]  = '{1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0};
    vec[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    2'b00, 32'h11BB_33DD};
    vec[5]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF,    2'b11, 32'h0};
    vec[6]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0,    2'b11, 32'h0};
    vec[7]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'hF,    2'b00, 32'h0};
    vec[8]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0,    2'b00, 32'hCAFE_F00D};
    vec[9]  = '{1'b0, 32'h0000_0007, 32'h0,         4'h0,    2'b00, 32'hDEAD_BEEF};
    vec[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    2'b11, 32'h0};

    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    rst = 1'b1;
    bus.araddr = 32'h0; bus.arid = 12'h0; bus.arlen = 4'h0; bus.arvalid = 1'b0;
    bus.arburst = 2'b01; bus.arsize = 3'd2; bus.arcache = 4'h0; bus.arlock = 2'b00;
    bus.arprot = 3'd0; bus.arqos = 4'h0; bus.rready = 1'b0;
    bus.awaddr = 32'h0; bus.awid = 12'h0; bus.awlen = 4'h0; bus.awvalid = 1'b0;
    bus.awburst = 2'b01; bus.awsize = 3'd2; bus.awcache = 4'h0; bus.awlock = 2'b00;
    bus.awprot = 3'd0; bus.awqos = 4'h0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.wid = 12'h0;
    bus.bready = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst arready", 32'(bus.arready), 32'd0);
    check("rst awready", 32'(bus.awready), 32'd0);
    check("rst wready",  32'(bus.wready),  32'd0);
    check("rst rvalid",  32'(bus.rvalid),  32'd0);
    check("rst rlast",   32'(bus.rlast),   32'd0);
    check("rst bvalid",  32'(bus.bvalid),  32'd0);
    check("rst rdata",   bus.rdata,        32'd0);
    check("rst rid",     32'(bus.rid),     32'd0);
    check("rst rresp",   32'(bus.rresp),   32'd0);
    check("rst bid",     32'(bus.bid),     32'd0);
    check("rst bresp",   32'(bus.bresp),   32'd0);
    check_regs("rst regs");
    rst = 1'b0;
    @(posedge aclk); #1;
    check("post-rst arready", 32'(bus.arready), 32'd1);
    check("post-rst awready", 32'(bus.awready), 32'd1);

    // Table of single-beat transfers
    for (int i = 0; i < 11; i++) begin
      if (vec[i].wr) begin
        do_write(vec[i].addr, 12'(i + 16), 4'd0, vec[i].data, vec[i].strb, resp, bid_r);
        model_write(vec[i].addr, vec[i].data, vec[i].strb);
        check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vec[i].exp_resp));
        check($sformatf("vec%0d bid", i), 32'(bid_r), 32'(i + 16));
        check_regs($sformatf("vec%0d regs", i));
      end else begin
        do_read(vec[i].addr, 12'(i + 32), 4'd0);
        check($sformatf("vec%0d beats", i), 32'(rd_n), 32'd1);
        check($sformatf("vec%0d rdata", i), rd_data[0], vec[i].exp_rdata);
        check($sformatf("vec%0d rresp", i), 32'(rd_resp[0]), 32'(vec[i].exp_resp));
        check($sformatf("vec%0d rlast", i), 32'(rd_last_v), 32'h1);
        check($sformatf("vec%0d rid", i), 32'(rd_id), 32'(i + 32));
      end
    end

    // Burst write 1..4 at 0x10, burst read back
    do_write(32'h10, 12'h123, 4'd3, 32'd1, 4'hF, resp, bid_r);
    for (int k = 0; k < 4; k++) model_write(32'h10 + 32'(4*k), 32'(k + 1), 4'hF);
    check("burst bresp", 32'(resp), 32'd0);
    check("burst bid", 32'(bid_r), 32'h123);
    check_regs("burst regs");
    do_read(32'h10, 12'h0A5, 4'd3);
    check("burst beats", 32'(rd_n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst rdata%0d", k), rd_data[k], 32'(k + 1));
      check($sformatf("burst rresp%0d", k), 32'(rd_resp[k]), 32'd0);
    end
    check("burst rlast pattern", 32'(rd_last_v), 32'h8);
    check("burst rid", 32'(rd_id), 32'h0A5);

    // Burst write crossing the top register: second beat out of range
    do_write(32'h3C, 12'h044, 4'd1, 32'h7000_0000, 4'hF, resp, bid_r);
    model_write(32'h3C, 32'h7000_0000, 4'hF);
    check("cross bresp", 32'(resp), 32'd3);
    check_regs("cross regs");

    // Read back-pressure: data held while rready low
    bus.araddr = 32'h14; bus.arid = 12'h003; bus.arlen = 4'd1; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    repeat (2) begin @(posedge aclk); #1; end
    check("bp rvalid held", 32'(bus.rvalid), 32'd1);
    check("bp rdata held", bus.rdata, 32'd2);
    check("bp rlast held", 32'(bus.rlast), 32'd0);
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    check("bp beat1 rdata", bus.rdata, 32'd3);
    check("bp beat1 rlast", 32'(bus.rlast), 32'd1);
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    check("bp done rvalid", 32'(bus.rvalid), 32'd0);

    // Back-to-back reads with arvalid held high
    do_write(32'h0, 12'h001, 4'd0, 32'd5, 4'hF, resp, bid_r);
    do_write(32'h4, 12'h002, 4'd0, 32'd9, 4'hF, resp, bid_r);
    model_write(32'h0, 32'd5, 4'hF);
    model_write(32'h4, 32'd9, 4'hF);
    bus.araddr = 32'h0; bus.arid = 12'h007; bus.arlen = 4'd0; bus.arvalid = 1'b1; bus.rready = 1'b1;
    nb = 0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      hs = bus.arvalid && bus.arready;
      if (bus.rvalid) begin
        if (nb < 4) begin bd[nb] = bus.rdata; bi[nb] = bus.rid; end
        nb++;
      end
      @(posedge aclk); #1;
      if (hs) begin
        acc++;
        if (acc == 1) begin bus.araddr = 32'h4; bus.arid = 12'h008; end
        else bus.arvalid = 1'b0;
      end
    end
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    check("b2b beats", 32'(nb), 32'd2);
    check("b2b data0", bd[0], 32'd5);
    check("b2b id0", 32'(bi[0]), 32'h007);
    check("b2b data1", bd[1], 32'd9);
    check("b2b id1", 32'(bi[1]), 32'h008);

    // Two consecutive writes, two B responses
    do_write(32'h8, 12'h021, 4'd0, 32'h0000_AAAA, 4'hF, resp, bid_r);
    check("w2 first bresp", 32'(resp), 32'd0);
    check("w2 first bid", 32'(bid_r), 32'h021);
    do_write(32'hC, 12'h022, 4'd0, 32'hBBBB_0000, 4'hF, resp, bid_r);
    check("w2 second bresp", 32'(resp), 32'd0);
    check("w2 second bid", 32'(bid_r), 32'h022);
    model_write(32'h8, 32'h0000_AAAA, 4'hF);
    model_write(32'hC, 32'hBBBB_0000, 4'hF);
    check_regs("w2 regs");

    // W presented together with AW
    bus.awaddr = 32'h20; bus.awid = 12'h055; bus.awlen = 4'd0; bus.awvalid = 1'b1;
    bus.wdata = 32'h5A5A_5A5A; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    check("earlyW wready idle", 32'(bus.wready), 32'd0);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    check("earlyW wready after AW", 32'(bus.wready), 32'd1);
    @(posedge aclk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    model_write(32'h20, 32'h5A5A_5A5A, 4'hF);
    check("earlyW bvalid", 32'(bus.bvalid), 32'd1);
    check("earlyW bresp", 32'(bus.bresp), 32'd0);
    check("earlyW bid", 32'(bus.bid), 32'h055);
    check_regs("earlyW regs");
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    check("earlyW bvalid cleared", 32'(bus.bvalid), 32'd0);

    // Reset in the middle of a 16-beat read
    bus.araddr = 32'h0; bus.arid = 12'h0EE; bus.arlen = 4'd15; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
    check("mid-read rvalid", 32'(bus.rvalid), 32'd1);
    rst = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    check("rst-abort rvalid", 32'(bus.rvalid), 32'd0);
    check("rst-abort arready", 32'(bus.arready), 32'd0);
    check_regs("rst-abort regs");
    rst = 1'b0; bus.rready = 1'b0;
    @(posedge aclk); #1;
    check("rst-abort rearm arready", 32'(bus.arready), 32'd1);
    check("rst-abort no rvalid", 32'(bus.rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi3_modport_slave.md
# axi3_modport_slave

AXI3 slave endpoint on the slave side of the `axi3_interface` bus: a bank of N_REGS 32-bit read/write registers reachable through single and INCR burst transactions. It sits behind the PS/interconnect AXI3 master port. It gives the bus tasks (readReg, writeReg, readReg_2, write_addr_2data_addr, readwriteReg) a real target, and exposes the register contents to fabric logic.

## Interface
- D_WIDTH, 32: data width; only 32 is supported.
- ID_WIDTH, 12: AXI ID width.
- N_REGS, 16: number of 32-bit registers; must be a power of two, at most 256.
- BASE_ADDR, 32'h0: byte address of register 0; must be aligned to 4*N_REGS.
- Clock/reset: one clock; reset is synchronous and active-high.
- aclk  in  1  bus clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- AR channel inputs:
  - araddr 32, arid ID_WIDTH, arlen 4, arvalid 1.
  - arburst, arsize, arcache, arlock, arprot and arqos are accepted and ignored.
- arready  out  1.
- rdata  out  32.
- rid  out  ID_WIDTH.
- rresp  out  2.
- rlast  out  1.
- rvalid  out  1.
- rready  in  1.
- AW channel inputs:
  - awaddr 32, awid ID_WIDTH, awlen 4, awvalid 1.
  - awburst, awsize, awcache, awlock, awprot and awqos are ignored.
- awready  out  1.
- wdata  in  32.
- wstrb  in  4.
- wlast  in  1.
- wvalid  in  1.
- wid  in  ID_WIDTH; ignored.
- wready  out  1.
- bid  out  ID_WIDTH.
- bresp  out  2.
- bvalid  out  1.
- bready  in  1.
- regs  out  32*N_REGS  current register contents; word i is at bits [32*i+31:32*i].

## Operation
- All bursts are treated as INCR with 4-byte beats. A transaction has len+1 beats, 1..16.
- Beat k addresses addr + 4*k. The address is word-aligned by dropping addr[1:0].
- A beat is in range when BASE_ADDR ≤ beat address < BASE_ADDR + 4*N_REGS. The register index is (beat address − BASE_ADDR) >> 2. The index never wraps.
- Read and write FSMs are independent and may run concurrently. Each FSM handles one transaction at a time; there is no outstanding queue.
- Read FSM, R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: arready=1. On arvalid&&arready, capture arid, arlen and the address, then go to R_DATA.
  - R_DATA: arready=0, rvalid=1, rid = the captured ID.
  - rdata is the beat's register, or 0 for an out-of-range beat.
  - rresp is 2'b00 in range, 2'b11 (DECERR) out of range.
  - rlast=1 on the final beat.
  - On rvalid&&rready the next beat is presented. After the last beat, return to R_IDLE.
- Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: awready=1, wready=0. On awvalid, capture awid and the address, then go to W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes the bytes enabled by wstrb[b] into the beat's register.
  - Out-of-range beats are dropped and set a sticky error flag.
  - The beat with wlast=1, or the (awlen+1)-th beat, whichever comes first, moves to W_RESP.
  - W_RESP: bvalid=1, bid = the captured awid.
  - bresp is 2'b11 if the error flag is set, else 2'b00.
  - On bready, clear the error flag and return to W_IDLE.
- If W data arrives together with or before AW, it waits: wready stays 0 until W_DATA.
- If a write and a read beat load touch the same register in the same cycle, the read returns the old value.

## Timing
- Reset values:
  - arready, awready, wready, rvalid, rlast, bvalid all 0.
  - rdata, rid, rresp, bid, bresp all 0.
  - All registers 0. FSMs in IDLE.
- arready and awready rise the first cycle after rst deasserts.
- arready/awready are registered state decodes, high for all of IDLE. Master signals are sampled at rising edges.
- Read latency: AR handshake at edge T → rvalid=1 with beat 0 valid after edge T; the master samples it at T+1.
- Throughput is 1 beat per cycle while rready=1. rdata/rresp/rlast are held stable while rvalid&&!rready.
- Write: AW handshake at T → wready=1 from T+1.
- Register update is visible on regs one cycle after the W handshake edge.
- bvalid is asserted the cycle after the last W handshake and held until bready.
- A new AR/AW is accepted the cycle after the R-last/B handshake. A held arvalid/awvalid is therefore accepted again at that point (back-to-back transactions).
- rst mid-transaction aborts both FSMs immediately. Partially written registers are cleared to 0. No response is produced.

## Test plan
- Single write then read: writeReg offset 0x4, value 0xDEADBEEF, then readReg offset 0x4 → bresp=0, rdata=0xDEADBEEF, rresp=0, rlast=1 on the only beat, rid=arid.
- Burst write then burst read:
  - writeReg len 3, values 1..4 at offset 0x10; then readReg len 3.
  - → 4 beats, rdata 1,2,3,4, rlast only on beat 3.
  - → regs words 4..7 = 1..4.
- Byte strobes: reg 0=0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 → reg 0 reads 0x11BB33DD.
- Out of range:
  - Write to offset 4*N_REGS → bresp=2'b11, no register changes.
  - Read from offset 4*N_REGS → rresp=2'b11, rdata=0.
- Back-to-back transactions:
  - readReg_2 at offset 0 with reg0=5, reg1=9 → two read bursts, arid then arid+1, data 5 then 9.
  - write_addr_2data_addr → both registers written, two B responses.
- Early W and reset:
  - readwriteReg with wvalid asserted alongside awvalid → the data lands after AW acceptance and bvalid is asserted.
  - rst during a 16-beat read → rvalid=0 and all registers 0 the next cycle.
